// File: rtl/clint_responder.sv
// Core-local interruptor responder: msip, mtimecmp and mtime on a one-cycle-latency memory bus.
// Optional msip register is enabled by defining CLINT_MSIP_EN.
module clint_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 50
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        IRQ3,
   output logic        IRQ7
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   localparam logic [13:0] WordMsip    = 14'h0000;
   localparam logic [13:0] WordCmpLo   = 14'h1000;
   localparam logic [13:0] WordCmpHi   = 14'h1001;
   localparam logic [13:0] WordTimeLo  = 14'h2FFE;
   localparam logic [13:0] WordTimeHi  = 14'h2FFF;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return res;
   endfunction

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [63:0]     mtime_q, mtime_d;
   logic [63:0]     mtimecmp_q, mtimecmp_d;
   logic            ready_q, ready_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            irq7_q, irq7_d;
   logic            msip_rd;

   logic        hit, acc, wr, tick;
   logic [13:0] word;
   logic [31:0] rd_val;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^mem_addr[1:0];

   assign hit  = mem_valid && (mem_addr[31:16] == BASE_ADDR[31:16]);
   assign acc  = hit && !ready_q;
   assign wr   = acc && (mem_wstrb != 4'b0000);
   assign word = mem_addr[15:2];
   assign tick = (cnt_q == CntMax);

`ifdef CLINT_MSIP_EN
   logic msip_q, msip_d;
   logic irq3_q;

   always_comb begin
      msip_d = msip_q;
      if (wr && (word == WordMsip) && mem_wstrb[0]) msip_d = mem_wdata[0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         msip_q <= 1'b0;
         irq3_q <= 1'b0;
      end else begin
         msip_q <= msip_d;
         irq3_q <= msip_q;
      end
   end

   assign msip_rd = msip_q;
   assign IRQ3    = irq3_q;
`else
   assign msip_rd = 1'b0;
   assign IRQ3    = 1'b0;
`endif

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;

      // Increment first so a same-cycle CPU write overrides only the bytes it strobes.
      mtime_d = mtime_q + {63'b0, tick};
      if (wr && (word == WordTimeLo)) begin
         mtime_d[31:0] = byte_merge(mtime_d[31:0], mem_wdata, mem_wstrb);
      end
      if (wr && (word == WordTimeHi)) begin
         mtime_d[63:32] = byte_merge(mtime_d[63:32], mem_wdata, mem_wstrb);
      end

      mtimecmp_d = mtimecmp_q;
      if (wr && (word == WordCmpLo)) begin
         mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
      end
      if (wr && (word == WordCmpHi)) begin
         mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
      end

      case (word)
         WordMsip:   rd_val = {31'b0, msip_rd};
         WordCmpLo:  rd_val = mtimecmp_q[31:0];
         WordCmpHi:  rd_val = mtimecmp_q[63:32];
         WordTimeLo: rd_val = mtime_q[31:0];
         WordTimeHi: rd_val = mtime_q[63:32];
         default:    rd_val = 32'h0;
      endcase

      ready_d = acc;
      rdata_d = acc ? rd_val : 32'h0;
      irq7_d  = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q      <= '0;
         mtime_q    <= 64'h0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         ready_q    <= 1'b0;
         rdata_q    <= 32'h0;
         irq7_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         irq7_q     <= irq7_d;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;
   assign IRQ7  = irq7_q;

endmodule
